// File: rtl/alu_cmd_issuer.sv
// Command FIFO and serialising issuer in front of a registered 4-op ALU.
// Each command is issued, its result captured, then returned with its tag.
module alu_cmd_issuer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic [2:0]                 cmd_op,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [2:0]                 alu_op,
    input  logic [2*WIDTH-1:0]         alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_result,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [2:0]       mem_op  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             cap;
    logic             rsp_clr;
    logic             fifo_empty;
    logic             head_err;
    logic [TAG_W-1:0] cur_tag;
    logic             cur_err;

    assign cmd_ready  = (fifo_count != CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = cmd_valid && cmd_ready;

    assign head_err = (mem_op[rd_ptr] > 3'b011) ||
                      ((mem_op[rd_ptr] == 3'b011) &&
                       (mem_b[rd_ptr] == '0));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= cmd_a;
            mem_b[wr_ptr]   <= cmd_b;
            mem_op[wr_ptr]  <= cmd_op;
            mem_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // A response handshake in RESP may chain straight into the next issue.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        cap      = 1'b0;
        rsp_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = CAPTURE;
            CAPTURE: begin
                cap      = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_clr = 1'b1;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = ISSUE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= 3'b000;
            cur_tag <= '0;
            cur_err <= 1'b0;
        end else if (pop) begin
            alu_a   <= mem_a[rd_ptr];
            alu_b   <= mem_b[rd_ptr];
            alu_op  <= mem_op[rd_ptr];
            cur_tag <= mem_tag[rd_ptr];
            cur_err <= head_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else if (cap) begin
            rsp_valid  <= 1'b1;
            rsp_result <= cur_err ? '0 : alu_result;
            rsp_tag    <= cur_tag;
            rsp_err    <= cur_err;
        end else if (rsp_clr) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural registered ALU.
// Directed commands push expected responses; a monitor checks each one.
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [1:0] cmd_tag;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [1:0] rsp_tag;
    logic       rsp_err;
    logic [2:0] fifo_count;
    logic       alu_rst;

    typedef struct packed {
        logic [7:0] res;
        logic [1:0] tag;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    alu_cmd_issuer #(.WIDTH(4), .DEPTH(4), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU resets active-high, so it sees the inverted block reset.
    assign alu_rst = ~rst;
    always_ff @(posedge clk or posedge alu_rst) begin
        if (alu_rst) alu_result <= 8'h00;
        else begin
            case (alu_op)
                3'b000: alu_result <= {4'h0, 4'(alu_a + alu_b)};
                3'b001: alu_result <= {4'h0, 4'(alu_a - alu_b)};
                3'b010: alu_result <= {4'h0, alu_a} * {4'h0, alu_b};
                3'b011: alu_result <= (alu_b != 0) ?
                                      {4'h0, alu_a / alu_b} : 8'hFF;
                default: alu_result <= 8'hAA;
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_result", int'(rsp_result), int'(e.res));
                chk("rsp_tag", int'(rsp_tag), int'(e.tag));
                chk("rsp_err", int'(rsp_err), int'(e.err));
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [1:0] tag,
                        input logic [7:0] res, input logic err);
        bit acc;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_tag = tag;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back('{res, tag, err});
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || rsp_valid) && i < 200) begin
            tick();
            i++;
        end
        chk("drain_timeout", (i < 200) ? 1 : 0, 1);
    endtask

    initial begin
        logic [7:0] held_res;
        logic [1:0] held_tag;
        rst = 1'b0;
        cmd_valid = 1'b1;
        cmd_a = 4'h7;
        cmd_b = 4'h2;
        cmd_op = 3'b000;
        cmd_tag = 2'd3;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_result", int'(rsp_result), 0);
        chk("rst_rsp_tag", int'(rsp_tag), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_count", int'(fifo_count), 0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_ready", int'(cmd_ready), 1);
        chk("post_rst_count", int'(fifo_count), 0);

        cmd_valid = 1'b1;
        cmd_a = 4'd3;
        cmd_b = 4'd5;
        cmd_op = 3'b000;
        cmd_tag = 2'd1;
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back('{8'h08, 2'd1, 1'b0});
        chk("lat_e0_valid", int'(rsp_valid), 0);
        tick();
        chk("lat_e1_valid", int'(rsp_valid), 0);
        chk("issue_alu_a", int'(alu_a), 3);
        chk("issue_alu_b", int'(alu_b), 5);
        chk("issue_count", int'(fifo_count), 0);
        tick();
        chk("lat_e2_valid", int'(rsp_valid), 0);
        tick();
        chk("lat_e3_valid", int'(rsp_valid), 1);
        tick();
        chk("rsp_drop", int'(rsp_valid), 0);
        drain();

        send(4'd15, 4'd15, 3'b010, 2'd2, 8'hE1, 1'b0);
        send(4'd2, 4'd5, 3'b001, 2'd3, 8'h0D, 1'b0);
        send(4'd9, 4'd0, 3'b011, 2'd0, 8'h00, 1'b1);
        send(4'd9, 4'd2, 3'b101, 2'd1, 8'h00, 1'b1);
        send(4'd9, 4'd2, 3'b011, 2'd2, 8'h04, 1'b0);
        drain();

        rsp_ready = 1'b0;
        send(4'd1, 4'd2, 3'b000, 2'd0, 8'h03, 1'b0);
        send(4'd4, 4'd3, 3'b010, 2'd1, 8'h0C, 1'b0);
        send(4'd7, 4'd1, 3'b001, 2'd2, 8'h06, 1'b0);
        send(4'd8, 4'd2, 3'b011, 2'd3, 8'h04, 1'b0);
        send(4'd15, 4'd1, 3'b000, 2'd0, 8'h00, 1'b0);
        repeat (4) tick();
        chk("bp_count", int'(fifo_count), 4);
        chk("bp_ready", int'(cmd_ready), 0);
        chk("bp_valid", int'(rsp_valid), 1);
        chk("bp_tag", int'(rsp_tag), 0);
        held_res = rsp_result;
        held_tag = rsp_tag;
        repeat (3) tick();
        chk("hold_valid", int'(rsp_valid), 1);
        chk("hold_result", int'(rsp_result), int'(held_res));
        chk("hold_tag", int'(rsp_tag), int'(held_tag));

        cmd_valid = 1'b1;
        cmd_a = 4'd6;
        cmd_b = 4'd6;
        cmd_op = 3'b010;
        cmd_tag = 2'd1;
        rsp_ready = 1'b1;
        chk("full_ready", int'(cmd_ready), 0);
        tick();
        chk("full_pop_count", int'(fifo_count), 3);
        chk("full_pop_ready", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back('{8'h24, 2'd1, 1'b0});
        chk("refill_count", int'(fifo_count), 4);
        drain();

        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_a = 4'(i + 1);
            cmd_b = 4'd1;
            cmd_op = 3'b000;
            cmd_tag = 2'(i);
            tick();
        end
        cmd_valid = 1'b0;
        chk("cap_count", int'(fifo_count), 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(rsp_valid), 0);
        chk("mid_rst_count", int'(fifo_count), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("after_rst_valid", int'(rsp_valid), 0);
        send(4'd5, 4'd5, 3'b000, 2'd3, 8'h0A, 1'b0);
        drain();
        chk("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
